// File: rtl/conv_pkg.sv
// Shared state encoding and default geometry for the convolution window scheduler.
package conv_pkg;

   localparam int unsigned DefImageWidth  = 224;
   localparam int unsigned DefImageHeight = 224;
   localparam int unsigned DefKernelSize  = 3;
   localparam int unsigned DefChannelNum  = 64;

   typedef logic [1:0] conv_state_t;

   localparam conv_state_t StIdle  = 2'd0;
   localparam conv_state_t StIssue = 2'd1;
   localparam conv_state_t StDrain = 2'd2;
   localparam conv_state_t StDone  = 2'd3;

   // A count of 1 still needs a 1-bit field.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Nested channel/column/row counter walking the output grid, channel innermost.
module conv_pos_counter
   import conv_pkg::*;
#(
   parameter int unsigned OUT_W       = 2,
   parameter int unsigned OUT_H       = 2,
   parameter int unsigned CHANNEL_NUM = 2,
   parameter int unsigned ROW_W       = 1,
   parameter int unsigned COL_W       = 1,
   parameter int unsigned CH_W        = 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             adv_i,
   output logic [ROW_W-1:0] row_o,
   output logic [COL_W-1:0] col_o,
   output logic [CH_W-1:0]  ch_o,
   output logic             ch_first_o,
   output logic             ch_last_o,
   output logic             pass_last_o
);

   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic             row_last, col_last, ch_last;

   assign ch_last  = (ch_q == CH_W'(CHANNEL_NUM - 1));
   assign col_last = (col_q == COL_W'(OUT_W - 1));
   assign row_last = (row_q == ROW_W'(OUT_H - 1));

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      ch_d  = ch_q;
      if (clear_i) begin
         row_d = '0;
         col_d = '0;
         ch_d  = '0;
      end else if (adv_i) begin
         if (ch_last) begin
            ch_d = '0;
            if (col_last) begin
               col_d = '0;
               row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end else begin
            ch_d = ch_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         row_q <= '0;
         col_q <= '0;
         ch_q  <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
         ch_q  <= ch_d;
      end
   end

   assign row_o       = row_q;
   assign col_o       = col_q;
   assign ch_o        = ch_q;
   assign ch_first_o  = (ch_q == '0);
   assign ch_last_o   = ch_last;
   assign pass_last_o = ch_last & col_last & row_last;

endmodule

// File: rtl/conv_window_scheduler.sv
// Issues convolution window requests over the output grid with a credit limit on
// positions awaiting MAC retirement.
module conv_window_scheduler
   import conv_pkg::*;
#(
   parameter int unsigned IMAGE_WIDTH     = DefImageWidth,
   parameter int unsigned IMAGE_HEIGHT    = DefImageHeight,
   parameter int unsigned KERNEL_SIZE     = DefKernelSize,
   parameter int unsigned CHANNEL_NUM     = DefChannelNum,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic                                   start_i,
   output logic                                   busy_o,
   output logic                                   done_o,
   output logic                                   win_valid_o,
   input  logic                                   win_ready_i,
   output logic [clog2_min1(IMAGE_HEIGHT)-1:0]    win_row_o,
   output logic [clog2_min1(IMAGE_WIDTH)-1:0]     win_col_o,
   output logic [clog2_min1(CHANNEL_NUM)-1:0]     win_ch_o,
   output logic                                   win_first_o,
   output logic                                   win_last_o,
   input  logic                                   res_ack_i,
   output logic                                   err_o
);

   localparam int unsigned OutW = IMAGE_WIDTH - KERNEL_SIZE + 1;
   localparam int unsigned OutH = IMAGE_HEIGHT - KERNEL_SIZE + 1;
   localparam int unsigned RowW = clog2_min1(IMAGE_HEIGHT);
   localparam int unsigned ColW = clog2_min1(IMAGE_WIDTH);
   localparam int unsigned ChW  = clog2_min1(CHANNEL_NUM);
   localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

   conv_state_t     state_q, state_d;
   logic [CntW-1:0] out_q, out_d;
   logic            err_q, err_d;
   logic            clear, hs, inc, dec;
   logic            ch_first, ch_last, pass_last;

   conv_pos_counter #(
      .OUT_W       (OutW),
      .OUT_H       (OutH),
      .CHANNEL_NUM (CHANNEL_NUM),
      .ROW_W       (RowW),
      .COL_W       (ColW),
      .CH_W        (ChW)
   ) u_pos (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .clear_i     (clear),
      .adv_i       (hs),
      .row_o       (win_row_o),
      .col_o       (win_col_o),
      .ch_o        (win_ch_o),
      .ch_first_o  (ch_first),
      .ch_last_o   (ch_last),
      .pass_last_o (pass_last)
   );

   // Only a fresh position waits for credit; channels of a started one never stall.
   assign win_valid_o = (state_q == StIssue) &&
                        !(ch_first && (out_q == CntW'(MAX_OUTSTANDING)));
   assign hs          = win_valid_o & win_ready_i;
   assign inc         = hs & ch_last;
   assign dec         = res_ack_i;

   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StIssue;
               clear   = 1'b1;
            end
         end
         StIssue: if (hs && pass_last) state_d = StDrain;
         StDrain: if (out_q == '0) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out_d = out_q;
      err_d = err_q;
      if (inc && !dec) begin
         out_d = out_q + 1'b1;
      end else if (dec && !inc) begin
         if (out_q == '0) err_d = 1'b1;
         else             out_d = out_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         out_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

   assign busy_o      = (state_q == StIssue) || (state_q == StDrain);
   assign done_o      = (state_q == StDone);
   assign win_first_o = ch_first;
   assign win_last_o  = ch_last;
   assign err_o       = err_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Scoreboard bench for conv_window_scheduler on a 4x4 map, 3x3 kernel, 2 channels.
module tb_conv_window_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       win_ready = 1'b0;
   logic       res_ack = 1'b0;
   logic       busy, done, win_valid, win_first, win_last, err;
   logic [1:0] win_row, win_col;
   logic [0:0] win_ch;

   int         n_cmp = 0;
   int         n_err = 0;
   int         hs_count = 0;
   int         done_cnt = 0;
   logic [6:0] sb_q[$];
   logic [2:0] ack_pipe = '0;
   logic       auto_ack = 1'b0;
   logic       manual_ack = 1'b0;

   always #5 clk = ~clk;

   conv_window_scheduler #(
      .IMAGE_WIDTH     (4),
      .IMAGE_HEIGHT    (4),
      .KERNEL_SIZE     (3),
      .CHANNEL_NUM     (2),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .start_i     (start),
      .busy_o      (busy),
      .done_o      (done),
      .win_valid_o (win_valid),
      .win_ready_i (win_ready),
      .win_row_o   (win_row),
      .win_col_o   (win_col),
      .win_ch_o    (win_ch),
      .win_first_o (win_first),
      .win_last_o  (win_last),
      .res_ack_i   (res_ack),
      .err_o       (err)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock: apply res_ack, observe handshakes at negedge, return 1 after posedge.
   task automatic cycle();
      logic [6:0] exp_beat;
      res_ack = manual_ack | (auto_ack & ack_pipe[0]);
      @(negedge clk);
      if (done) done_cnt++;
      if (win_valid && win_ready) begin
         hs_count++;
         if (win_last) ack_pipe[2] = 1'b1;
         if (sb_q.size() == 0) begin
            check_eq("extra_beat", {win_row, win_col, win_ch, win_first, win_last}, 32'hffff);
         end else begin
            exp_beat = sb_q.pop_front();
            check_eq($sformatf("beat%0d", hs_count),
                     {win_row, win_col, win_ch, win_first, win_last}, exp_beat);
         end
      end
      @(posedge clk);
      #1;
      ack_pipe = ack_pipe >> 1;
   endtask

   task automatic start_pass(input bit push);
      if (push) begin
         for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
               for (int ch = 0; ch < 2; ch++)
                  sb_q.push_back({r[1:0], c[1:0], ch[0], ch == 0, ch == 1});
      end
      hs_count = 0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      check_eq("valid_after_start", win_valid, 1);
      check_eq("busy_after_start", busy, 1);
   endtask

   task automatic run_until_hs(input int target, input int budget);
      for (int i = 0; i < budget && hs_count < target; i++) cycle();
      check_eq("hs_reached", hs_count >= target, 1);
   endtask

   task automatic run_until_done(input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) cycle();
      check_eq("done_once", done_cnt - d0, 1);
      cycle();
      check_eq("done_single_pulse", done_cnt - d0, 1);
      check_eq("busy_after_done", busy, 0);
      check_eq("sb_empty", sb_q.size(), 0);
   endtask

   task automatic ack_once();
      manual_ack = 1'b1;
      cycle();
      manual_ack = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_valid", win_valid, 0);
      check_eq("rst_pos", {win_row, win_col, win_ch}, 0);
      reset = 1'b0;
      cycle();
      check_eq("idle_done", done, 0);
      check_eq("idle_err", err, 0);

      // Full pass with delayed acks
      win_ready = 1'b1;
      auto_ack = 1'b1;
      start_pass(1);
      run_until_done(100);
      check_eq("pass1_beats", hs_count, 8);
      check_eq("pass1_err", err, 0);

      // Back-pressure on the third beat
      start_pass(1);
      run_until_hs(2, 20);
      win_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq("stall_valid", win_valid, 1);
         check_eq("stall_pos", {win_row, win_col, win_ch}, 5'b00010);
         cycle();
      end
      win_ready = 1'b1;
      run_until_done(100);
      check_eq("pass2_beats", hs_count, 8);

      // Credit exhaustion
      auto_ack = 1'b0;
      start_pass(1);
      run_until_hs(4, 20);
      cycle();
      cycle();
      check_eq("credit_block_valid", win_valid, 0);
      check_eq("credit_block_pos", {win_row, win_col, win_ch}, 5'b01000);
      check_eq("credit_block_busy", busy, 1);
      ack_once();
      check_eq("credit_resume", win_valid, 1);
      ack_once();
      auto_ack = 1'b1;
      run_until_done(100);
      check_eq("pass3_err", err, 0);

      // Ack coincident with a win_last handshake
      auto_ack = 1'b0;
      start_pass(1);
      run_until_hs(3, 20);
      ack_once();
      check_eq("coinc_hs", hs_count, 4);
      check_eq("coinc_next_valid", win_valid, 1);
      run_until_hs(6, 20);
      check_eq("coinc_full_block", win_valid, 0);
      check_eq("coinc_err", err, 0);
      ack_once();
      ack_once();
      auto_ack = 1'b1;
      run_until_done(100);

      // Spurious ack in IDLE, then a start during ISSUE
      ack_once();
      check_eq("err_set", err, 1);
      repeat (3) cycle();
      check_eq("err_sticky", err, 1);
      start_pass(1);
      cycle();
      start = 1'b1;
      cycle();
      start = 1'b0;
      run_until_done(100);
      check_eq("pass5_beats", hs_count, 8);
      check_eq("err_still", err, 1);

      // Reset mid-pass while the fifth beat is presented
      start_pass(1);
      run_until_hs(4, 20);
      reset = 1'b1;
      #1;
      check_eq("mid_rst_valid", win_valid, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_pos", {win_row, win_col, win_ch}, 0);
      check_eq("mid_rst_err", err, 0);
      check_eq("mid_rst_done", done, 0);
      sb_q.delete();
      ack_pipe = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      done_cnt = 0;
      cycle();
      check_eq("no_done_after_rst", done_cnt, 0);
      start_pass(1);
      run_until_done(100);
      check_eq("pass6_beats", hs_count, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
